// File: rtl/mac_dot_driver_pkg.sv
// Shared types and default widths for the MAC dot-product driver and its wrapper.
package mac_dot_driver_pkg;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int LEN_BW  = 10;
  localparam int MAC_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_dot_driver_mac_wrapper.sv
// Pipelined multiply-accumulate: out = zext(a) * sext(b) + c, mac_lat cycles after the operands.
module mac_wrapper #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int mac_lat = 2
) (
  input  logic               clk,
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] out
);

  logic [psum_bw-1:0] a_ext;
  logic [psum_bw-1:0] b_ext;
  logic [psum_bw-1:0] sum;
  logic [psum_bw-1:0] pipe_q [mac_lat];

  // Truncating the product of the extended operands yields the result modulo 2^psum_bw.
  always_comb begin
    a_ext = {{(psum_bw-bw){1'b0}}, a};
    b_ext = {{(psum_bw-bw){b[bw-1]}}, b};
    sum   = a_ext * b_ext + c;
  end

  // NOTE: the datapath pipeline has no reset; the controller samples it only
  // mac_lat cycles after presenting fresh operands, so stale contents never escape.
  always_ff @(posedge clk) begin
    pipe_q[0] <= sum;
    for (int i = 1; i < mac_lat; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out = pipe_q[mac_lat-1];

endmodule

// File: rtl/mac_dot_driver.sv
// Dot-product controller: accepts len (activation, weight) pairs, loops psum back through
// mac_wrapper as c, and presents the final sum on a valid/ready result port.
module mac_dot_driver
  import mac_dot_driver_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int len_bw  = LEN_BW,
  parameter int mac_lat = MAC_LAT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum,
  output logic               busy
);

  localparam int WC_W = $clog2(mac_lat + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(mac_lat);

  state_e             state_q, state_d;
  logic [len_bw-1:0]  cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [psum_bw-1:0] acc_q, acc_d, c_q, c_d, mac_out;
  logic [bw-1:0]      a_q, a_d, b_q, b_d;

  mac_wrapper #(
    .bw      (bw),
    .psum_bw (psum_bw),
    .mac_lat (mac_lat)
  ) u_mac (
    .clk (clk),
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .out (mac_out)
  );

  assign cnt_inc = cnt_q + len_bw'(1);

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    wait_cnt_d = wait_cnt_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_b;
          c_d        = acc_q;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Operands have been on the wrapper for mac_lat+1 cycles once wait_cnt hits mac_lat.
        if (wait_cnt_q == WAIT_LAST) begin
          acc_d   = mac_out;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? DONE : ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      wait_cnt_q <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      wait_cnt_q <= wait_cnt_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
    end
  end

  assign in_ready  = (state_q == ISSUE);
  assign out_valid = (state_q == DONE);
  assign out_psum  = (state_q == DONE) ? acc_q : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_dot_driver.sv
// Directed and randomised checks of mac_dot_driver against hand-computed and modelled sums.
module tb_mac_dot_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_psum;
  logic        busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  mac_dot_driver dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    len   = 10'(n);
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
  endtask

  // Presents one pair and returns the cycle in which the handshake completes.
  task automatic push(input logic [3:0] a, input logic [3:0] b, output int hs_cyc);
    int budget = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget < 40) begin
      step();
      budget++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", in_ready, 1);
    hs_cyc = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int seen);
    int budget = 0;
    while (out_valid !== 1'b1 && budget < 40) begin
      step();
      budget++;
    end
    if (out_valid !== 1'b1) check("out_valid_timeout", out_valid, 1);
    seen = cyc;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("after_out_valid", out_valid, 0);
    check("after_out_busy", busy, 0);
  endtask

  initial begin
    int t1, t2, t3, td, gap, n, ai, bi, model;
    logic [3:0] ra, rb;
    logic [31:0] m32;

    reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_psum", out_psum, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    // 3*2 + 5*(-1) + 15*(-8) = -119, pairs back to back
    start_run(3);
    push(4'd3, 4'd2, t1);
    push(4'd5, 4'hF, t2);
    push(4'd15, 4'h8, t3);
    check("t1_spacing_12", t2 - t1, 4);
    check("t1_spacing_23", t3 - t2, 4);
    wait_out(td);
    check("t1_out_latency", td - t3, 4);
    check("t1_psum", out_psum, 16'hFF89);
    finish_out();

    // Zero-length run goes straight to DONE
    start = 1'b1;
    len   = 10'd0;
    step();
    start = 1'b0;
    check("t2_out_valid", out_valid, 1);
    check("t2_psum", out_psum, 0);
    check("t2_in_ready", in_ready, 0);
    finish_out();

    // 7*3 + 2*(-4) = 13, result held under back-pressure while start is ignored
    start_run(2);
    push(4'd7, 4'd3, t1);
    push(4'd2, 4'hC, t2);
    wait_out(td);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_psum", out_psum, 16'h000D);
      check("t3_hold_busy", busy, 1);
      start = 1'b1;
      len   = 10'd5;
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check("t3_start_in_hs_ignored", busy, 0);
    step();
    check("t3_idle_after", busy, 0);

    // 600 x (15*7) = 63000 with random input gaps
    start_run(600);
    for (int i = 0; i < 600; i++) begin
      gap = int'($urandom_range(0, 3));
      in_valid = 1'b0;
      repeat (gap) step();
      push(4'd15, 4'd7, t1);
    end
    wait_out(td);
    check("t4_psum", out_psum, 16'hF618);
    finish_out();

    // Reset during WAIT of pair 2 of 4, then a fresh single-pair run
    start_run(4);
    push(4'd1, 4'd1, t1);
    push(4'd2, 4'd2, t2);
    check("t5_in_wait", in_ready, 0);
    reset_n = 1'b0;
    step();
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_psum", out_psum, 0);
    check("t5_rst_busy", busy, 0);
    reset_n = 1'b1;
    step();
    start_run(1);
    push(4'd4, 4'hE, t1);
    wait_out(td);
    check("t5_psum", out_psum, 16'hFFF8);
    finish_out();

    // Randomised lengths and pairs against an integer reference model
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 20));
      model = 0;
      start_run(n);
      for (int k = 0; k < n; k++) begin
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        ai = int'(ra);
        bi = (rb > 4'd7) ? int'(rb) - 16 : int'(rb);
        model = model + ai * bi;
        gap = int'($urandom_range(0, 2));
        in_valid = 1'b0;
        repeat (gap) step();
        push(ra, rb, t1);
      end
      wait_out(td);
      m32 = model;
      check("t6_psum", out_psum, {16'h0, m32[15:0]});
      finish_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
